// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/redirect controller for the RISC-V core.
// Optional bus watchdog built when PIPE_CTRL_BUS_TIMEOUT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 255,
  parameter logic [31:0] TRAP_ADDR    = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  input  logic        jtag_halt_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        bus_timeout_o,
  output logic        halted_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {RUN, FLUSH, STALL, HALT} state_e;

  state_e      state_q;
  logic [2:0]  hold_q;
  logic        jump_flag_q;
  logic [31:0] jump_addr_q;
  logic        halted_q;
  logic [3:0]  flush_cnt_q;

  logic        wd_expire;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [2:0]  hold_req;

  always_comb begin
    redirect      = wd_expire | int_assert_i | jump_flag_i;
    redirect_addr = jump_addr_i;
    if (wd_expire) begin
      redirect_addr = TRAP_ADDR;
    end else if (int_assert_i) begin
      redirect_addr = int_addr_i;
    end
    hold_req = HOLD_NONE;
    if (hold_ex_i) begin
      hold_req = HOLD_ID;
    end else if (hold_bus_i) begin
      hold_req = HOLD_PC;
    end
  end

  // RUN and STALL share one decision path; they differ only in the hold they drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      hold_q      <= HOLD_NONE;
      jump_flag_q <= 1'b0;
      jump_addr_q <= 32'h0;
      halted_q    <= 1'b0;
      flush_cnt_q <= 4'd0;
    end else begin
      jump_flag_q <= 1'b0;
      if (jtag_halt_i) begin
        state_q     <= HALT;
        hold_q      <= HOLD_ID;
        halted_q    <= 1'b1;
        flush_cnt_q <= 4'd0;
      end else if (state_q == HALT) begin
        state_q  <= RUN;
        hold_q   <= HOLD_NONE;
        halted_q <= 1'b0;
      end else if (redirect) begin
        state_q     <= FLUSH;
        hold_q      <= HOLD_ID;
        jump_flag_q <= 1'b1;
        jump_addr_q <= redirect_addr;
        flush_cnt_q <= 4'(FLUSH_CYCLES);
      end else if (state_q == FLUSH && flush_cnt_q > 4'd1) begin
        hold_q      <= HOLD_ID;
        flush_cnt_q <= flush_cnt_q - 4'd1;
      end else begin
        flush_cnt_q <= 4'd0;
        hold_q      <= hold_req;
        state_q     <= (hold_req != HOLD_NONE) ? STALL : RUN;
      end
    end
  end

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  logic [15:0] wdog_cnt_q;
  logic        bus_timeout_q;

  assign wd_expire = hold_bus_i && (state_q != HALT) &&
                     (wdog_cnt_q == 16'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q    <= 16'd0;
      bus_timeout_q <= 1'b0;
    end else begin
      // A simultaneous halt takes the redirect slot, so no pulse is reported.
      bus_timeout_q <= wd_expire && !jtag_halt_i;
      if (!hold_bus_i || wd_expire) begin
        wdog_cnt_q <= 16'd0;
      end else if (state_q != HALT) begin
        wdog_cnt_q <= wdog_cnt_q + 16'd1;
      end
    end
  end

  assign bus_timeout_o = bus_timeout_q;
`else
  logic unused_bus_timeout;
  assign unused_bus_timeout = ^BUS_TIMEOUT;
  assign wd_expire          = 1'b0;
  assign bus_timeout_o      = 1'b0;
`endif

  assign hold_flag_o = hold_q;
  assign jump_flag_o = jump_flag_q;
  assign jump_addr_o = jump_addr_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a cycle reference model.
module tb_pipe_ctrl;
  localparam int unsigned FC = 2;
  localparam int unsigned BT = 8;
  localparam logic [31:0] TA = 32'h0000_0010;
`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, int_assert_i, hold_ex_i, hold_bus_i, jtag_halt_i;
  logic [31:0] jump_addr_i, int_addr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o, bus_timeout_o, halted_o;
  logic [31:0] jump_addr_o;

  int checks = 0;
  int errors = 0;

  bit          m_halted;
  int          m_flush_left;
  int          m_wd;
  logic [2:0]  e_hold;
  logic        e_jf, e_bto, e_halted;
  logic [31:0] e_addr;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .BUS_TIMEOUT(BT), .TRAP_ADDR(TA)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i), .jtag_halt_i(jtag_halt_i),
    .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .bus_timeout_o(bus_timeout_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_halted = 0; m_flush_left = 0; m_wd = 0;
    e_hold = 3'd0; e_jf = 0; e_bto = 0; e_halted = 0; e_addr = 32'h0;
  endfunction

  // Expected outputs after the next rising edge, from the currently driven inputs.
  function automatic void model_step();
    bit was_halted = m_halted;
    bit wd_fire = WD_EN && hold_bus_i && !m_halted && (m_wd + 1 == int'(BT));
    e_jf = 0;
    e_bto = 0;
    if (jtag_halt_i) begin
      m_halted = 1; m_flush_left = 0; e_hold = 3'd3; e_halted = 1;
    end else if (m_halted) begin
      m_halted = 0; e_hold = 3'd0; e_halted = 0;
    end else if (wd_fire || int_assert_i || jump_flag_i) begin
      e_jf = 1;
      e_bto = wd_fire;
      e_addr = wd_fire ? TA : (int_assert_i ? int_addr_i : jump_addr_i);
      m_flush_left = FC;
      e_hold = 3'd3;
    end else if (m_flush_left > 1) begin
      m_flush_left--;
      e_hold = 3'd3;
    end else begin
      m_flush_left = 0;
      e_hold = hold_ex_i ? 3'd3 : (hold_bus_i ? 3'd1 : 3'd0);
    end
    if (!hold_bus_i || wd_fire) m_wd = 0;
    else if (!was_halted) m_wd++;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jump_flag_i = 0; int_assert_i = 0; hold_ex_i = 0; hold_bus_i = 0; jtag_halt_i = 0;
    jump_addr_i = 32'h0; int_addr_i = 32'h0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, halted_o} !== 38'h0) begin
      errors++;
      $display("FAIL reset_init: got hold=%0d jf=%0b addr=%h bto=%0b halted=%0b, need all 0",
               hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, halted_o);
    end
    rst = 1;
    hold_ex_i = 1;
    tick();
    checks++;
    if (hold_flag_o !== 3'd3) begin
      errors++;
      $display("FAIL reset_stall_setup: hold=%0d need 3", hold_flag_o);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (hold_flag_o !== 3'd0 || halted_o !== 1'b0 || jump_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: hold=%0d jf=%0b halted=%0b need 0", hold_flag_o, jump_flag_o, halted_o);
    end
    hold_ex_i = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    tick();
    checks++;
    if (hold_flag_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: hold=%0d need 0", hold_flag_o);
    end
  endtask

  task automatic test_jump();
    jump_flag_i = 1; jump_addr_i = 32'h0000_0200;
    tick();
    jump_flag_i = 0; jump_addr_i = 32'h0;
    checks++;
    if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h200 || hold_flag_o !== 3'd3) begin
      errors++;
      $display("FAIL jump_pulse: jf=%0b addr=%h hold=%0d need 1/00000200/3", jump_flag_o, jump_addr_o, hold_flag_o);
    end
    tick();
    checks++;
    if (jump_flag_o !== 1'b0 || hold_flag_o !== 3'd3 || jump_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL jump_flush2: jf=%0b hold=%0d addr=%h need 0/3/00000200", jump_flag_o, hold_flag_o, jump_addr_o);
    end
    tick();
    checks++;
    if (hold_flag_o !== 3'd0) begin
      errors++;
      $display("FAIL jump_end: hold=%0d need 0", hold_flag_o);
    end
  endtask

  task automatic test_collision();
    int extra = 0;
    int_assert_i = 1; int_addr_i = 32'h0000_0080;
    jump_flag_i = 1; jump_addr_i = 32'h0000_0200;
    tick();
    int_assert_i = 0; jump_flag_i = 0;
    checks++;
    if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h80) begin
      errors++;
      $display("FAIL collision_addr: jf=%0b addr=%h need 1/00000080", jump_flag_o, jump_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (jump_flag_o) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL collision_single: extra pulses=%0d need 0", extra);
    end
  endtask

  task automatic test_stall();
    hold_bus_i = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hold_flag_o !== 3'd1) begin
        errors++;
        $display("FAIL stall_bus[%0d]: hold=%0d need 1", i, hold_flag_o);
      end
    end
    hold_bus_i = 0;
    tick();
    checks++;
    if (hold_flag_o !== 3'd0) begin
      errors++;
      $display("FAIL stall_drop: hold=%0d need 0", hold_flag_o);
    end
    hold_bus_i = 1;
    tick();
    hold_ex_i = 1;
    tick();
    checks++;
    if (hold_flag_o !== 3'd3) begin
      errors++;
      $display("FAIL stall_ex_raise: hold=%0d need 3", hold_flag_o);
    end
    hold_ex_i = 0;
    tick();
    checks++;
    if (hold_flag_o !== 3'd1) begin
      errors++;
      $display("FAIL stall_ex_drop: hold=%0d need 1", hold_flag_o);
    end
    hold_bus_i = 0;
    tick();
  endtask

  task automatic test_halt();
    jtag_halt_i = 1;
    tick();
    checks++;
    if (halted_o !== 1'b1 || hold_flag_o !== 3'd3) begin
      errors++;
      $display("FAIL halt_enter: halted=%0b hold=%0d need 1/3", halted_o, hold_flag_o);
    end
    jump_flag_i = 1; jump_addr_i = 32'h0000_0444;
    tick();
    jump_flag_i = 0;
    checks++;
    if (jump_flag_o !== 1'b0 || halted_o !== 1'b1) begin
      errors++;
      $display("FAIL halt_ignore_jump: jf=%0b halted=%0b need 0/1", jump_flag_o, halted_o);
    end
    jtag_halt_i = 0;
    tick();
    checks++;
    if (halted_o !== 1'b0 || hold_flag_o !== 3'd0) begin
      errors++;
      $display("FAIL halt_release: halted=%0b hold=%0d need 0/0", halted_o, hold_flag_o);
    end
    tick();
    checks++;
    if (jump_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_not_latched: jf=%0b need 0", jump_flag_o);
    end
  endtask

  task automatic test_watchdog();
    int fire_at = 0;
    bit hold_ok = 1;
    hold_bus_i = 1;
    for (int i = 1; i <= 20 && fire_at == 0; i++) begin
      tick();
      if (bus_timeout_o) begin
        fire_at = i;
        checks++;
        if (jump_flag_o !== 1'b1 || jump_addr_o !== TA) begin
          errors++;
          $display("FAIL wdog_redirect: jf=%0b addr=%h need 1/%h", jump_flag_o, jump_addr_o, TA);
        end
      end else if (jump_flag_o || hold_flag_o !== 3'd1) begin
        hold_ok = 0;
      end
    end
    checks++;
    if (WD_EN && fire_at != int'(BT)) begin
      errors++;
      $display("FAIL wdog_fire_cycle: fired at %0d need %0d", fire_at, BT);
    end else if (!WD_EN && (fire_at != 0 || !hold_ok)) begin
      errors++;
      $display("FAIL wdog_disabled: fired at %0d hold_ok=%0b need 0/1", fire_at, hold_ok);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL wdog_stall_hold: stall cycles not all Hold_Pc without pulse");
    end
    hold_bus_i = 0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      jtag_halt_i  = ($urandom_range(0, 15) == 0) ? ~jtag_halt_i : jtag_halt_i;
      int_assert_i = ($urandom_range(0, 9) == 0);
      int_addr_i   = $urandom;
      jump_flag_i  = ($urandom_range(0, 5) == 0);
      jump_addr_i  = $urandom;
      hold_ex_i    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) hold_bus_i = ~hold_bus_i;
      tick();
      checks++;
      if (hold_flag_o !== e_hold || jump_flag_o !== e_jf || jump_addr_o !== e_addr ||
          bus_timeout_o !== e_bto || halted_o !== e_halted) begin
        errors++;
        $display("FAIL random[%0d]: got hold=%0d jf=%0b addr=%h bto=%0b halted=%0b need hold=%0d jf=%0b addr=%h bto=%0b halted=%0b",
                 c, hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, halted_o,
                 e_hold, e_jf, e_addr, e_bto, e_halted);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_collision();
    test_stall();
    test_halt();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
